// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: two chained half adders and a carry flip-flop process one
// operand bit per clock, LSB first, behind valid/ready handshakes on both sides.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic s1, c1, s2, c2, carry_next;

    always_comb begin
        s1         = a_sh[0] ^ b_sh[0];
        c1         = a_sh[0] & b_sh[0];
        s2         = s1 ^ carry;
        c2         = s1 & carry;
        carry_next = c1 | c2;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == ADD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            ovf_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    carry <= carry_next;
                    res   <= {s2, res[WIDTH-1:1]};
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        // On the MSB cycle, carry still holds the carry into the MSB.
                        sum_out  <= {s2, res[WIDTH-1:1]};
                        cout_out <= carry_next;
                        ovf_out  <= carry ^ carry_next;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
